// File: rtl/ft232h_tx_sched_if.sv
// rtl/ft232h_tx_sched_if.sv - requester streams and FT232H bus bundle for ft232h_tx_sched
interface ft232h_tx_sched_if;
  logic [7:0]  ch0_data_i;
  logic        ch0_valid_i;
  logic        ch0_ready_o;
  logic [7:0]  ch1_data_i;
  logic        ch1_valid_i;
  logic        ch1_ready_o;
  logic        ft_txe_i;
  logic        ft_wr_o;
  logic [7:0]  ft_adbus_o;
  logic [1:0]  grant_o;
  logic [15:0] byte_cnt_o;

  modport slave (
    input  ch0_data_i, ch0_valid_i, ch1_data_i, ch1_valid_i, ft_txe_i,
    output ch0_ready_o, ch1_ready_o, ft_wr_o, ft_adbus_o, grant_o, byte_cnt_o
  );

  modport master (
    output ch0_data_i, ch0_valid_i, ch1_data_i, ch1_valid_i, ft_txe_i,
    input  ch0_ready_o, ch1_ready_o, ft_wr_o, ft_adbus_o, grant_o, byte_cnt_o
  );
endinterface

// File: rtl/ft232h_tx_sched.sv
// rtl/ft232h_tx_sched.sv - two-requester round-robin burst scheduler onto the FT232H FIFO bus
// Define FT_TX_HDR_EN to prefix each burst with a header byte HDR_BASE | channel id.
module ft232h_tx_sched #(
  parameter int         BURST_LEN = 64,
  parameter logic [7:0] HDR_BASE  = 8'hA0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ft232h_tx_sched_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;
  localparam logic [7:0] BL     = 8'(BURST_LEN);

  logic [1:0]  r_state;
  logic        r_wr_n;
  logic [7:0]  r_data;
  logic [1:0]  r_grant;
  logic [15:0] r_cnt;
  logic        r_last;
  logic [7:0]  r_loaded;

  logic       w_accept;
  logic       w_stage_free;
  logic       w_room;
  logic       w_gvalid;
  logic [7:0] w_gdata;
  logic       w_take;
  logic       w_load;
  logic       w_pick;

  assign w_accept     = !r_wr_n && !bus.ft_txe_i;
  assign w_stage_free = r_wr_n || w_accept;
  assign w_room       = (r_loaded != BL);
  assign w_gvalid     = r_grant[1] ? bus.ch1_valid_i : bus.ch0_valid_i;
  assign w_gdata      = r_grant[1] ? bus.ch1_data_i  : bus.ch0_data_i;
  assign w_take       = (r_state == S_DATA) && w_stage_free && w_room && !rst_i;
  assign w_load       = w_take && w_gvalid;
  // Tie goes to the channel not granted last; r_last holds the last granted id.
  assign w_pick       = (bus.ch0_valid_i && bus.ch1_valid_i) ? ~r_last : bus.ch1_valid_i;

  assign bus.ch0_ready_o = w_take && r_grant[0];
  assign bus.ch1_ready_o = w_take && r_grant[1];
  assign bus.ft_wr_o     = r_wr_n;
  assign bus.ft_adbus_o  = r_data;
  assign bus.grant_o     = r_grant;
  assign bus.byte_cnt_o  = r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_wr_n   <= 1'b1;
      r_data   <= 8'h00;
      r_grant  <= 2'b00;
      r_cnt    <= 16'd0;
      r_last   <= 1'b1;
      r_loaded <= 8'd0;
    end else begin
      if (w_accept) begin
        r_cnt <= r_cnt + 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.ch0_valid_i || bus.ch1_valid_i) begin
            r_grant  <= w_pick ? 2'b10 : 2'b01;
            r_last   <= w_pick;
            r_loaded <= 8'd0;
`ifdef FT_TX_HDR_EN
            r_data   <= HDR_BASE | {7'd0, w_pick};
            r_wr_n   <= 1'b0;
            r_state  <= S_HDR;
`else
            r_state  <= S_DATA;
`endif
          end
        end
`ifdef FT_TX_HDR_EN
        S_HDR: begin
          if (w_accept) begin
            r_wr_n  <= 1'b1;
            r_state <= S_DATA;
          end
        end
`endif
        S_DATA: begin
          if (w_load) begin
            r_data   <= w_gdata;
            r_wr_n   <= 1'b0;
            r_loaded <= r_loaded + 8'd1;
          end else begin
            if (w_accept) begin
              r_wr_n <= 1'b1;
            end
            // Leave only once the stage drains, so no burst ends with a byte pending.
            if (w_stage_free && (!w_room || !w_gvalid)) begin
              r_grant <= 2'b00;
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ft232h_tx_sched.sv
// tb/tb_ft232h_tx_sched.sv - scoreboard bench for ft232h_tx_sched
module tb_ft232h_tx_sched;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_w = 1'b1;
  always #5 clk = ~clk;

  ft232h_tx_sched_if bus();
  ft232h_tx_sched_if wbus();

  ft232h_tx_sched #(.BURST_LEN(BL), .HDR_BASE(8'hA0)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  ft232h_tx_sched #(.BURST_LEN(255), .HDR_BASE(8'hA0)) dut_w (
    .clk_i(clk), .rst_i(rst_w), .bus(wbus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] src0[$];
  logic [7:0] src1[$];
  logic [7:0] exp_q[$];
  logic [1:0] exp_grant[$];

  logic       hs0 = 1'b0;
  logic       hs1 = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  int         burst_n = 0;
  int         w_acc = 0;
  logic [2:0] w_done = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester drivers: present queue heads, retire on handshake.
  always @(posedge clk) begin
    #1;
    if (hs0 && src0.size() > 0) void'(src0.pop_front());
    if (hs1 && src1.size() > 0) void'(src1.pop_front());
    bus.ch0_valid_i = (src0.size() > 0);
    bus.ch0_data_i  = (src0.size() > 0) ? src0[0] : 8'h00;
    bus.ch1_valid_i = (src1.size() > 0);
    bus.ch1_data_i  = (src1.size() > 0) ? src1[0] : 8'h00;
  end

  always @(negedge clk) begin
    hs0 = bus.ch0_valid_i && bus.ch0_ready_o;
    hs1 = bus.ch1_valid_i && bus.ch1_ready_o;
    if (!rst) begin
      if (prev_grant == 2'b00 && bus.grant_o != 2'b00) begin
        burst_n = 0;
        chk("grant_pending", 32'(exp_grant.size() != 0), 32'd1);
        if (exp_grant.size() != 0) chk("grant", 32'(bus.grant_o), 32'(exp_grant.pop_front()));
`ifdef FT_TX_HDR_EN
        exp_q.push_back(8'hA0 | {7'd0, bus.grant_o[1]});
`endif
      end
      if (prev_grant != 2'b00 && bus.grant_o == 2'b00) begin
        chk("gap_wr_high", 32'(bus.ft_wr_o), 32'd1);
        chk("gap_stage_drained", 32'(exp_q.size()), 32'd0);
        chk("burst_len_ok", 32'(burst_n <= BL), 32'd1);
      end
      if (!bus.ft_wr_o && !bus.ft_txe_i) begin
        chk("bus_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("bus_byte", 32'(bus.ft_adbus_o), 32'(exp_q.pop_front()));
      end
      if (hs0) begin exp_q.push_back(bus.ch0_data_i); burst_n++; end
      if (hs1) begin exp_q.push_back(bus.ch1_data_i); burst_n++; end
    end
    prev_grant = bus.grant_o;
  end

  initial begin
    wbus.ch0_valid_i = 1'b0;
    wbus.ch0_data_i  = 8'h5A;
    wbus.ch1_valid_i = 1'b0;
    wbus.ch1_data_i  = 8'h00;
    wbus.ft_txe_i    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_w = 1'b0;
    wbus.ch0_valid_i = 1'b1;
  end

  // Counter wrap: compare against accepts seen so far, before this edge's accept.
  always @(negedge clk) begin
    if (!rst_w) begin
      if (w_acc == 65535 && !w_done[0]) begin w_done[0] = 1'b1; chk("wrap_ffff", 32'(wbus.byte_cnt_o), 32'h0000FFFF); end
      if (w_acc == 65536 && !w_done[1]) begin w_done[1] = 1'b1; chk("wrap_0000", 32'(wbus.byte_cnt_o), 32'h00000000); end
      if (w_acc == 65539 && !w_done[2]) begin w_done[2] = 1'b1; chk("wrap_0003", 32'(wbus.byte_cnt_o), 32'h00000003); end
      if (!wbus.ft_wr_o && !wbus.ft_txe_i) w_acc++;
    end
  end

  task automatic drain(input string tag);
    int n = 0;
    while ((src0.size() != 0 || src1.size() != 0 || exp_q.size() != 0 ||
            exp_grant.size() != 0 || bus.grant_o != 2'b00) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_drain"}, 32'(n < 400), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_bus(input string tag, input logic [7:0] val);
    int n = 0;
    while (!(bus.ft_adbus_o == val && !bus.ft_wr_o) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_seen"}, 32'(n < 100), 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.ft_txe_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wr", 32'(bus.ft_wr_o), 32'd1);
    chk("rst_bus", 32'(bus.ft_adbus_o), 32'd0);
    chk("rst_grant", 32'(bus.grant_o), 32'd0);
    chk("rst_cnt", 32'(bus.byte_cnt_o), 32'd0);
    chk("rst_ready0", 32'(bus.ch0_ready_o), 32'd0);
    chk("rst_ready1", 32'(bus.ch1_ready_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single short burst from ch0.
    exp_grant.push_back(2'b01);
    src0.push_back(8'h11); src0.push_back(8'h22); src0.push_back(8'h33);
    drain("single");
`ifdef FT_TX_HDR_EN
    chk("single_cnt", 32'(bus.byte_cnt_o), 32'd4);
`else
    chk("single_cnt", 32'(bus.byte_cnt_o), 32'd3);
`endif

    // Both requesters continuously valid: grants alternate from ch0.
    pulse_reset();
    for (int i = 0; i < 12; i++) begin
      src0.push_back(8'h40 + 8'(i));
      src1.push_back(8'h80 + 8'(i));
    end
    for (int i = 0; i < 3; i++) begin
      exp_grant.push_back(2'b01);
      exp_grant.push_back(2'b10);
    end
    drain("alternate");

    // TXE# stall with 0x22 presented.
    exp_grant.push_back(2'b01);
    src0.push_back(8'h11); src0.push_back(8'h22); src0.push_back(8'h33); src0.push_back(8'h44);
    wait_bus("stall", 8'h22);
    bus.ft_txe_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_wr", 32'(bus.ft_wr_o), 32'd0);
      chk("stall_bus", 32'(bus.ft_adbus_o), 32'h22);
    end
    @(posedge clk); #1;
    bus.ft_txe_i = 1'b0;
    drain("stall");

    // ch1 alone, five bytes: two bursts.
    exp_grant.push_back(2'b10);
    exp_grant.push_back(2'b10);
    for (int i = 0; i < 5; i++) src1.push_back(8'h51 + 8'(i));
    drain("ch1_five");
`ifdef FT_TX_HDR_EN
    chk("total_cnt", 32'(bus.byte_cnt_o), 32'd42);
`else
    chk("total_cnt", 32'(bus.byte_cnt_o), 32'd33);
`endif

    // Reset mid-burst: pending byte dropped, pointer back to ch0.
    exp_grant.push_back(2'b01);
    for (int i = 0; i < 8; i++) src0.push_back(8'h60 + 8'(i));
    wait_bus("midrst", 8'h62);
    bus.ft_txe_i = 1'b1;
    rst = 1'b1;
    src0.delete(); src1.delete(); exp_q.delete(); exp_grant.delete();
    @(negedge clk);
    chk("midrst_ready0", 32'(bus.ch0_ready_o), 32'd0);
    chk("midrst_ready1", 32'(bus.ch1_ready_o), 32'd0);
    @(posedge clk); #1;
    chk("midrst_wr", 32'(bus.ft_wr_o), 32'd1);
    chk("midrst_bus", 32'(bus.ft_adbus_o), 32'd0);
    chk("midrst_grant", 32'(bus.grant_o), 32'd0);
    chk("midrst_cnt", 32'(bus.byte_cnt_o), 32'd0);
    rst = 1'b0;
    bus.ft_txe_i = 1'b0;
    exp_grant.push_back(2'b01);
    exp_grant.push_back(2'b10);
    src0.push_back(8'h70); src0.push_back(8'h71);
    src1.push_back(8'h90); src1.push_back(8'h91);
    drain("post_rst_tie");

    begin
      int n = 0;
      while (w_acc < 65540 && n < 90000) begin @(posedge clk); n++; end
      chk("wrap_done", 32'(w_acc >= 65540), 32'd1);
    end
    chk("wrap_points", 32'(w_done), 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
